// File: rtl/bcd_conversion_scheduler_pkg.sv
// rtl/bcd_conversion_scheduler_pkg.sv - shared types and constants for the BCD conversion scheduler
package bcd_pkg;

    typedef enum logic {
        OCIOSO   = 1'b0,
        CONVERTE = 1'b1
    } estado_t;

    typedef enum logic {
        FONTE_CPU = 1'b0,
        FONTE_DBG = 1'b1
    } fonte_t;

    localparam int BCD_DIG_W = 4;
    localparam int NUM_DIG   = 3;
    localparam int BCD_W     = BCD_DIG_W * NUM_DIG;

    // Double-dabble correction: a digit of 5 or more would overflow past 9 once doubled.
    function automatic logic [BCD_DIG_W-1:0] ajusta(input logic [BCD_DIG_W-1:0] d);
        return (d >= BCD_DIG_W'(5)) ? d + BCD_DIG_W'(3) : d;
    endfunction

endpackage

// File: rtl/bcd_conversion_scheduler_if.sv
// rtl/bcd_conversion_scheduler_if.sv - requester handshakes and display bus of the BCD scheduler
interface bcd_conversion_scheduler_if;

    logic        req_cpu;
    logic [31:0] dado_cpu;
    logic        ack_cpu;
    logic        req_dbg;
    logic [31:0] dado_dbg;
    logic        ack_dbg;
    logic        busy;
    logic        sinal;
    logic [3:0]  centena;
    logic [3:0]  dezena;
    logic [3:0]  unidade;
    logic        fonte;
    logic        atualizado;

    modport master (
        output req_cpu, dado_cpu, req_dbg, dado_dbg,
        input  ack_cpu, ack_dbg, busy, sinal, centena, dezena, unidade, fonte, atualizado
    );

    modport slave (
        input  req_cpu, dado_cpu, req_dbg, dado_dbg,
        output ack_cpu, ack_dbg, busy, sinal, centena, dezena, unidade, fonte, atualizado
    );

endinterface

// File: rtl/bcd_conversion_scheduler_passo.sv
// rtl/bcd_conversion_scheduler_passo.sv - one add-3 and shift iteration of the double-dabble converter
module bcd_passo_dabble
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_in,
    input  logic             bit_in,
    output logic [BCD_W-1:0] bcd_out
);

    logic [BCD_W-1:0] ajustado;

    // Correct every digit, then shift the next binary bit into the units digit.
    always_comb begin
        ajustado = '0;
        for (int i = 0; i < NUM_DIG; i++) begin
            ajustado[i*BCD_DIG_W +: BCD_DIG_W] = ajusta(bcd_in[i*BCD_DIG_W +: BCD_DIG_W]);
        end
        bcd_out = {ajustado[BCD_W-2:0], bit_in};
    end

endmodule

// File: rtl/bcd_conversion_scheduler.sv
// rtl/bcd_conversion_scheduler.sv - round-robin shared sequential binary-to-BCD converter for the display
module bcd_conversion_scheduler
    import bcd_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    bcd_conversion_scheduler_if.slave     bus
);

    // One extra magnitude bit so that -2^(DATA_W-1) negates exactly.
    localparam int MAG_W = DATA_W + 1;
    localparam int CNT_W = $clog2(MAG_W + 1);

    estado_t           estado_q, estado_d;
    fonte_t            ultimo_q;
    logic              conc_cpu, conc_dbg;
    logic              fim;
    logic [DATA_W-1:0] op_sel;
    logic [MAG_W-1:0]  op_ext, mag_ini, mag_q;
    logic [BCD_W-1:0]  bcd_q, bcd_prox;
    logic [CNT_W-1:0]  cnt_q;
    logic              sinal_w;
    fonte_t            fonte_w;

    logic              ack_cpu_r, ack_dbg_r, atualizado_r;
    logic              sinal_r;
    fonte_t            fonte_r;
    logic [3:0]        centena_r, dezena_r, unidade_r;

    logic              bits_unused;
    assign bits_unused = ^{bus.dado_cpu[31:DATA_W], bus.dado_dbg[31:DATA_W]};

    assign fim = (estado_q == CONVERTE) && (cnt_q == CNT_W'(1));

    // Arbitration and next state: ties go to whoever was not served last.
    always_comb begin
        estado_d = estado_q;
        conc_cpu = 1'b0;
        conc_dbg = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (bus.req_cpu && bus.req_dbg) begin
                    conc_cpu = (ultimo_q == FONTE_DBG);
                    conc_dbg = (ultimo_q == FONTE_CPU);
                end else begin
                    conc_cpu = bus.req_cpu;
                    conc_dbg = bus.req_dbg;
                end
                if (conc_cpu || conc_dbg) begin
                    estado_d = CONVERTE;
                end
            end
            CONVERTE: begin
                if (fim) begin
                    estado_d = OCIOSO;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    // Operand of the granted side, turned into sign + magnitude.
    always_comb begin
        op_sel  = conc_dbg ? bus.dado_dbg[DATA_W-1:0] : bus.dado_cpu[DATA_W-1:0];
        op_ext  = {op_sel[DATA_W-1], op_sel};
        mag_ini = op_sel[DATA_W-1] ? (~op_ext + MAG_W'(1)) : op_ext;
    end

    bcd_passo_dabble u_passo (
        .bcd_in  (bcd_q),
        .bit_in  (mag_q[MAG_W-1]),
        .bcd_out (bcd_prox)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= OCIOSO;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Capture, shift datapath and display registers; display only changes on the final shift.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ultimo_q     <= FONTE_DBG;
            mag_q        <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            sinal_w      <= 1'b0;
            fonte_w      <= FONTE_CPU;
            ack_cpu_r    <= 1'b0;
            ack_dbg_r    <= 1'b0;
            atualizado_r <= 1'b0;
            sinal_r      <= 1'b0;
            fonte_r      <= FONTE_CPU;
            centena_r    <= '0;
            dezena_r     <= '0;
            unidade_r    <= '0;
        end else begin
            ack_cpu_r    <= conc_cpu;
            ack_dbg_r    <= conc_dbg;
            atualizado_r <= fim;
            if (conc_cpu || conc_dbg) begin
                mag_q    <= mag_ini;
                bcd_q    <= '0;
                cnt_q    <= CNT_W'(MAG_W);
                sinal_w  <= op_sel[DATA_W-1];
                fonte_w  <= conc_dbg ? FONTE_DBG : FONTE_CPU;
                ultimo_q <= conc_dbg ? FONTE_DBG : FONTE_CPU;
            end else if (estado_q == CONVERTE) begin
                bcd_q <= bcd_prox;
                mag_q <= {mag_q[MAG_W-2:0], 1'b0};
                cnt_q <= cnt_q - CNT_W'(1);
                if (fim) begin
                    sinal_r   <= sinal_w;
                    fonte_r   <= fonte_w;
                    centena_r <= bcd_prox[11:8];
                    dezena_r  <= bcd_prox[7:4];
                    unidade_r <= bcd_prox[3:0];
                end
            end
        end
    end

    assign bus.ack_cpu    = ack_cpu_r;
    assign bus.ack_dbg    = ack_dbg_r;
    assign bus.atualizado = atualizado_r;
    assign bus.busy       = (estado_q == CONVERTE);
    assign bus.sinal      = sinal_r;
    assign bus.fonte      = fonte_r;
    assign bus.centena    = centena_r;
    assign bus.dezena     = dezena_r;
    assign bus.unidade    = unidade_r;

endmodule
